butterfly_collector: RTL and testbench
======================================

BUTTERFLY_COLLECTOR -- requirements
Module: butterfly_collector

Interface
REQ-001 Parameter: WIDTH, default 16, bit width of one real or imaginary result word.
REQ-002 Parameter: DEPTH, default 4, number of complex result entries in the output FIFO; a power of two, at least 2.
REQ-003 Port: clk  input  1  single clock; every register updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: cap_en  input  1  butterfly result-write strobe; capture the word on cap_data this cycle.
REQ-006 Port: cap_addr  input  1  result slot: 0 = first half (real), 1 = second half (imag).
REQ-007 Port: cap_data  input  WIDTH  butterfly result word.
REQ-008 Port: flush  input  1  synchronous clear of the FIFO, the holding register and the pairing state.
REQ-009 Port: clr_flags  input  1  synchronous clear of the sticky flags.
REQ-010 Port: out_ready  input  1  downstream accepts the head entry.
REQ-011 Port: out_valid  output  1  head entry present; equals !empty.
REQ-012 Port: out_re / out_im  output  WIDTH each  head entry; first-word-fall-through.
REQ-013 Port: level  output  clog2(DEPTH)+1  number of occupied entries.
REQ-014 Port: full / empty  output  1 each  FIFO status, combinational from level.
REQ-015 Port: overflow / seq_err  output  1 each  sticky error flags.

Function
REQ-016 Pairing FSM shall have two states: WAIT_LO (reset state) and WAIT_HI.
REQ-017 In WAIT_LO, cap_en with cap_addr=0 shall load cap_data into the holding register and move to WAIT_HI.
REQ-018 In WAIT_LO, cap_en with cap_addr=1 (orphan second half, e.g. the pipeline priming write) shall be discarded, shall set seq_err, and the FSM shall stay in WAIT_LO.
REQ-019 In WAIT_HI, cap_en with cap_addr=1 shall push {holding, cap_data} as {re, im} and return to WAIT_LO.
REQ-020 In WAIT_HI, cap_en with cap_addr=0 shall overwrite the holding register, shall set seq_err, and the FSM shall stay in WAIT_HI.
REQ-021 Cycles without cap_en shall leave the FSM and the holding register unchanged; there is no timeout.
REQ-022 A push shall be written in the capturing cycle; out_valid shall rise the following cycle when the FIFO was empty (1-cycle latency).
REQ-023 A pop shall occur when out_valid && out_ready; the head shall advance on that edge.
REQ-024 A push while full with no pop in the same cycle shall be dropped, shall set overflow, and the FIFO contents shall be unchanged.
REQ-025 A push and a pop in the same cycle while full shall both take effect; level shall be unchanged and overflow shall not be set.
REQ-026 A push and a pop in the same cycle with 0 < level < DEPTH shall leave level unchanged.
REQ-027 out_ready while empty shall have no effect.
REQ-028 Read and write pointers shall wrap modulo DEPTH; level shall range 0..DEPTH.
REQ-029 out_re and out_im shall be held stable while out_valid && !out_ready.
REQ-030 flush shall have priority over capture, push and pop in the same cycle: level becomes 0 and the FSM returns to WAIT_LO; the flags are unaffected.
REQ-031 clr_flags shall clear both flags; an error event in the same cycle as clr_flags shall win, and the flag shall be set.
REQ-032 No arithmetic is performed on data; words pass bit-exact.

Reset
REQ-033 While rst=0: FSM in WAIT_LO, holding register 0, pointers 0, level 0, out_valid 0, empty 1, full 0, overflow 0, seq_err 0, and out_re/out_im 0.
REQ-034 Reset asserted mid-pair or mid-transfer shall discard all contents immediately; after deassertion the first accepted capture shall be a cap_addr=0 write.

Verification
REQ-035 Basic pair: cap(0,0x1234) then cap(1,0xABCD) -> next cycle out_valid=1, out_re=0x1234, out_im=0xABCD, level=1.
REQ-036 Priming orphan: after reset cap(1,0x0005), then pair (0x0001, 0x0002) -> seq_err=1, exactly one entry {0x0001, 0x0002}.
REQ-037 Fill and overflow: out_ready=0, push DEPTH+1 pairs -> full=1, level=DEPTH, overflow=1, and popping yields the first DEPTH pairs in order.
REQ-038 Full with simultaneous push and pop: level stays DEPTH, overflow stays 0, and the popped entry is the oldest.
REQ-039 Repeated half: cap(0,0x0011), cap(0,0x0022), cap(1,0x0033) -> seq_err=1, entry {0x0022, 0x0033}.
REQ-040 Reset mid-pair: cap(0,0x00AA), rst pulse, cap(1,0x00BB) -> no entry, seq_err=1, level=0.

Source files
------------

// File: rtl/butterfly_collector.sv
// Pairs butterfly real/imag result words into complex entries and queues them
// in a small first-word-fall-through FIFO with sticky sequencing/overflow flags.
module butterfly_collector #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cap_en,
    input  logic                     cap_addr,
    input  logic [WIDTH-1:0]         cap_data,
    input  logic                     flush,
    input  logic                     clr_flags,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_re,
    output logic [WIDTH-1:0]         out_im,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     seq_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
    localparam logic [0:0] WAIT_LO = 1'b0;
    localparam logic [0:0] WAIT_HI = 1'b1;

    logic [0:0]         state;
    logic [WIDTH-1:0]   hold;
    logic [AW-1:0]      wptr, rptr;
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [2*WIDTH-1:0] head;

    logic push_req, push_ok, pop, seq_ev, ovf_ev;

    assign empty     = (level == '0);
    assign full      = (level == FULL_LVL);
    assign out_valid = !empty;
    assign head      = mem[rptr];
    // Gate the head so outputs read zero whenever nothing is queued (incl. reset).
    assign out_re    = empty ? '0 : head[2*WIDTH-1:WIDTH];
    assign out_im    = empty ? '0 : head[WIDTH-1:0];

    assign pop      = !flush && out_valid && out_ready;
    assign push_req = !flush && cap_en && cap_addr && (state == WAIT_HI);
    assign push_ok  = push_req && (!full || pop);
    assign ovf_ev   = push_req && full && !pop;
    assign seq_ev   = !flush && cap_en &&
                      ((state == WAIT_LO) ? cap_addr : !cap_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_LO;
            hold  <= '0;
        end else if (flush) begin
            state <= WAIT_LO;
            hold  <= '0;
        end else if (cap_en) begin
            if (!cap_addr) begin
                hold  <= cap_data;
                state <= WAIT_HI;
            end else begin
                state <= WAIT_LO;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= {hold, cap_data};
    end

    // An error event in the clearing cycle still leaves its flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            overflow <= (overflow && !clr_flags) || ovf_ev;
            seq_err  <= (seq_err && !clr_flags) || seq_ev;
        end
    end
endmodule

// File: tb/tb_butterfly_collector.sv
// Randomized and directed check of butterfly_collector against a queue-based
// model of the pairing and FIFO rules.
module tb_butterfly_collector;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk = 0, rst = 0;
    logic cap_en = 0, cap_addr = 0, flush = 0, clr_flags = 0, out_ready = 0;
    logic [WIDTH-1:0] cap_data = '0;
    logic out_valid, full, empty, overflow, seq_err;
    logic [WIDTH-1:0] out_re, out_im;
    logic [$clog2(DEPTH):0] level;

    butterfly_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cap_en(cap_en), .cap_addr(cap_addr),
        .cap_data(cap_data), .flush(flush), .clr_flags(clr_flags),
        .out_ready(out_ready), .out_valid(out_valid), .out_re(out_re),
        .out_im(out_im), .level(level), .full(full), .empty(empty),
        .overflow(overflow), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // reference model: a queue of {re,im}, a pending real half, two flags
    logic [31:0] q[$];
    bit have_lo;
    logic [15:0] lo;
    bit m_ovf, m_seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] hd;
        hd = (q.size() > 0) ? q[0] : 32'h0;
        chk({tag, ".valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, ".re"},    32'(out_re),    32'(hd[31:16]));
        chk({tag, ".im"},    32'(out_im),    32'(hd[15:0]));
        chk({tag, ".level"}, 32'(level),     32'(q.size()));
        chk({tag, ".full"},  32'(full),      32'(q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty),     32'(q.size() == 0));
        chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
        chk({tag, ".seq"},   32'(seq_err),   32'(m_seq));
    endtask

    task automatic model_step(input bit en, input bit addr, input logic [15:0] d,
                              input bit rdy, input bit fl, input bit clr);
        bit do_pop, want_push;
        logic [31:0] entry;
        want_push = 0;
        if (clr) begin m_ovf = 0; m_seq = 0; end
        if (fl) begin
            q.delete();
            have_lo = 0;
            return;
        end
        do_pop = rdy && (q.size() > 0);
        if (en) begin
            if (!addr) begin
                if (have_lo) m_seq = 1;
                lo = d;
                have_lo = 1;
            end else if (!have_lo) begin
                m_seq = 1;
            end else begin
                want_push = 1;
                entry = {lo, d};
                have_lo = 0;
            end
        end
        if (want_push && q.size() == DEPTH && !do_pop) m_ovf = 1;
        if (do_pop) void'(q.pop_front());
        if (want_push && (q.size() < DEPTH)) q.push_back(entry);
    endtask

    task automatic cycle(input string tag, input bit en, input bit addr, input logic [15:0] d,
                         input bit rdy, input bit fl, input bit clr);
        cap_en = en; cap_addr = addr; cap_data = d;
        out_ready = rdy; flush = fl; clr_flags = clr;
        model_step(en, addr, d, rdy, fl, clr);
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        cap_en = 0; cap_addr = 0; cap_data = '0;
        out_ready = 0; flush = 0; clr_flags = 0;
        rst = 0;
        q.delete(); have_lo = 0; lo = '0; m_ovf = 0; m_seq = 0;
        #2;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic clean();
        cycle("clean", 0, 0, 16'h0, 0, 1, 1);
    endtask

    initial begin
        do_reset();

        // basic pair
        cycle("bp0", 1, 0, 16'h1234, 0, 0, 0);
        cycle("bp1", 1, 1, 16'hABCD, 0, 0, 0);
        chk("bp.re", 32'(out_re), 32'h1234);
        chk("bp.im", 32'(out_im), 32'hABCD);
        chk("bp.level", 32'(level), 32'd1);
        cycle("bp.pop", 0, 0, 16'h0, 1, 0, 0);

        // priming orphan
        do_reset();
        cycle("po0", 1, 1, 16'h0005, 0, 0, 0);
        cycle("po1", 1, 0, 16'h0001, 0, 0, 0);
        cycle("po2", 1, 1, 16'h0002, 0, 0, 0);
        chk("po.seq", 32'(seq_err), 32'd1);
        chk("po.level", 32'(level), 32'd1);
        chk("po.head", {16'(out_re), 16'(out_im)}, 32'h0001_0002);

        // fill and overflow
        clean();
        for (int i = 0; i <= DEPTH; i++) begin
            cycle("fo.lo", 1, 0, 16'(16'h1000 + i), 0, 0, 0);
            cycle("fo.hi", 1, 1, 16'(16'h2000 + i), 0, 0, 0);
        end
        chk("fo.full", 32'(full), 32'd1);
        chk("fo.level", 32'(level), DEPTH);
        chk("fo.ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("fo.order", {16'(out_re), 16'(out_im)}, {16'(16'h1000 + i), 16'(16'h2000 + i)});
            cycle("fo.pop", 0, 0, 16'h0, 1, 0, 0);
        end
        chk("fo.empty", 32'(empty), 32'd1);

        // full with simultaneous push and pop
        clean();
        for (int i = 0; i < DEPTH; i++) begin
            cycle("fp.lo", 1, 0, 16'(16'h3000 + i), 0, 0, 0);
            cycle("fp.hi", 1, 1, 16'(16'h4000 + i), 0, 0, 0);
        end
        cycle("fp.lo", 1, 0, 16'h3FFF, 0, 0, 0);
        chk("fp.oldest", {16'(out_re), 16'(out_im)}, 32'h3000_4000);
        cycle("fp.both", 1, 1, 16'h4FFF, 1, 0, 0);
        chk("fp.level", 32'(level), DEPTH);
        chk("fp.ovf", 32'(overflow), 32'd0);
        chk("fp.next", {16'(out_re), 16'(out_im)}, 32'h3001_4001);

        // repeated half
        clean();
        cycle("rh0", 1, 0, 16'h0011, 0, 0, 0);
        cycle("rh1", 1, 0, 16'h0022, 0, 0, 0);
        cycle("rh2", 1, 1, 16'h0033, 0, 0, 0);
        chk("rh.seq", 32'(seq_err), 32'd1);
        chk("rh.head", {16'(out_re), 16'(out_im)}, 32'h0022_0033);

        // reset mid-pair
        clean();
        cycle("rm0", 1, 0, 16'h00AA, 0, 0, 0);
        do_reset();
        cycle("rm1", 1, 1, 16'h00BB, 0, 0, 0);
        chk("rm.seq", 32'(seq_err), 32'd1);
        chk("rm.level", 32'(level), 32'd0);

        // clr_flags loses to a same-cycle error event
        cycle("cf", 1, 1, 16'h0001, 0, 0, 1);
        chk("cf.seq", 32'(seq_err), 32'd1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle("rnd", $urandom_range(0, 9) < 7, 1'($urandom), 16'($urandom),
                       1'($urandom), $urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
